div_operand_issuer: RTL and testbench

- Front-end sequencer sitting directly upstream of the unsigned restoring-division controller/datapath.
- Accepts dividend/divisor pairs over a valid/ready handshake and buffers them in a small FIFO.
- Issues a one-cycle start to the divider core, holds operands stable while the core runs, then captures quotient/remainder and presents them downstream over valid/ready.
- Handles divide-by-zero locally without invoking the core.

---
 rtl/div_operand_issuer.sv | 161 ++++++++++++++++
 tb/tb_div_operand_issuer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_issuer.sv
// rtl/div_operand_issuer.sv - operand FIFO and start/hold sequencer in front of a restoring divider
// Defining DIV_TIMEOUT_EN adds a watchdog that forces an error result after TIMEOUT_CYC cycles in WAIT.
module div_operand_issuer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             start,
    output logic [WIDTH-1:0] dividend_o,
    output logic [WIDTH-1:0] divisor_o,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_q,
    input  logic [WIDTH-1:0] core_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dbz,
    output logic             out_err,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
            $error("div_operand_issuer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] mem_dividend [DEPTH];
    logic [WIDTH-1:0] mem_divisor  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign in_ready   = !i_rst && !fifo_full;
    assign push       = in_valid && in_ready;
    // The head is only released once its result has been taken downstream.
    assign pop        = (state == S_HOLD) && out_ready;

    assign start      = (state == S_ISSUE);
    assign out_valid  = (state == S_HOLD);
    assign dividend_o = mem_dividend[rd_ptr];
    assign divisor_o  = mem_divisor[rd_ptr];
    assign busy       = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_dividend[wr_ptr] <= in_dividend;
            mem_divisor[wr_ptr]  <= in_divisor;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DIV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            out_q   <= '0;
            out_r   <= '0;
            out_dbz <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            err_q   <= 1'b0;
            wd_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (divisor_o == '0) begin
                            out_q   <= '1;
                            out_r   <= dividend_o;
                            out_dbz <= 1'b1;
`ifdef DIV_TIMEOUT_EN
                            err_q   <= 1'b0;
`endif
                            state   <= S_HOLD;
                        end else begin
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef DIV_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        out_q   <= core_q;
                        out_r   <= core_r;
                        out_dbz <= 1'b0;
`ifdef DIV_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state   <= S_HOLD;
                    end
`ifdef DIV_TIMEOUT_EN
                    // wd_cnt holds the number of WAIT cycles already completed.
                    else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                        out_q   <= '0;
                        out_r   <= '0;
                        out_dbz <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= S_HOLD;
                    end else begin
                        wd_cnt  <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_operand_issuer.sv
// tb/tb_div_operand_issuer.sv - directed bench with queue model and mock divider core
// Covers the DIV_TIMEOUT_EN watchdog when that macro is defined, otherwise checks WAIT never self-exits.
module tb_div_operand_issuer;
    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         start;
    logic [W-1:0] dividend_o;
    logic [W-1:0] divisor_o;
    logic         core_done;
    logic [W-1:0] core_q;
    logic [W-1:0] core_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_q;
    logic [W-1:0] out_r;
    logic         out_dbz;
    logic         out_err;
    logic         busy;

    div_operand_issuer #(.WIDTH(W), .DEPTH(2), .TIMEOUT_CYC(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .start(start), .dividend_o(dividend_o), .divisor_o(divisor_o),
        .core_done(core_done), .core_q(core_q), .core_r(core_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .out_err(out_err),
        .busy(busy)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        check("push_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check(name, out_valid, 1);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!start && n < 20) begin
            tick();
            n++;
        end
        check(name, start, 1);
    endtask

    // Mock divider core: answers each start with a/b after core_delay cycles.
    logic         core_mute = 1'b0;
    logic         noise     = 1'b0;
    int           core_delay = 5;
    logic [W-1:0] ma, mb;

    initial begin
        core_done = 1'b0;
        core_q    = '0;
        core_r    = '0;
        forever begin
            @(posedge i_clk);
            #2;
            core_done = 1'b0;
            if (noise) begin
                core_done = 1'($urandom);
                core_q    = W'($urandom);
                core_r    = W'($urandom);
            end else if (start && !core_mute) begin
                ma = dividend_o;
                mb = divisor_o;
                repeat (core_delay) @(posedge i_clk);
                #2;
                core_done = 1'b1;
                core_q    = (mb == 0) ? '1 : ma / mb;
                core_r    = (mb == 0) ? ma : ma % mb;
            end
        end
    end

    // Reference model: operand pairs in flight, results derived with plain arithmetic.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;
    pair_t        mq[$];
    logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, prev_start = 1'b0;
    logic [W-1:0] pq, pr;
    logic         pd, pe;
    logic [W-1:0] eq, er;
    logic         ed;
    int           start_cnt = 0;
    pair_t        np;

    always @(negedge i_clk) begin
        if (i_rst) begin
            check("in_ready_in_reset", in_ready, 0);
            mq.delete();
        end else begin
            check("in_ready", in_ready, 32'(mq.size() < 2));
            check("busy", busy, 32'(mq.size() != 0));
            if (mq.size() == 0) begin
                check("no_valid_when_empty", out_valid, 0);
            end else begin
                check("head_dividend", dividend_o, mq[0].a);
                check("head_divisor", divisor_o, mq[0].b);
            end
            if (start) begin
                start_cnt++;
                check("start_nonzero_divisor", 32'(mq.size() != 0 && mq[0].b != 0), 1);
                check("start_single_cycle", prev_start, 0);
            end
            if (prev_valid && !prev_ready && !prev_rst) begin
                check("hold_valid", out_valid, 1);
                check("hold_q", out_q, pq);
                check("hold_r", out_r, pr);
                check("hold_dbz", out_dbz, pd);
                check("hold_err", out_err, pe);
            end
`ifndef DIV_TIMEOUT_EN
            check("err_tied_low", out_err, 0);
`endif
            if (out_valid && out_ready && mq.size() != 0) begin
                if (out_err) begin
                    eq = '0; er = '0; ed = 1'b0;
                end else if (mq[0].b == 0) begin
                    eq = '1; er = mq[0].a; ed = 1'b1;
                end else begin
                    eq = mq[0].a / mq[0].b; er = mq[0].a % mq[0].b; ed = 1'b0;
                end
                check("model_q", out_q, eq);
                check("model_r", out_r, er);
                check("model_dbz", out_dbz, ed);
                void'(mq.pop_front());
            end
            if (in_valid && in_ready) begin
                np.a = in_dividend;
                np.b = in_divisor;
                mq.push_back(np);
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_rst   = i_rst;
        prev_start = start;
        pq = out_q; pr = out_r; pd = out_dbz; pe = out_err;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    int           n;
    int           base;
    logic         seen;
    logic [W-1:0] hq, hr;
    logic [W-1:0] exp_q [3];
    logic [W-1:0] exp_r [3];

    initial begin
        i_rst       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_start", start, 0);
        check("rst_out_q", out_q, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        i_rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // 200/7, core answers 20 cycles after start
        core_delay = 20;
        base = start_cnt;
        push(8'd200, 8'd7);
        tick();
        check("t1_start", start, 1);
        wait_valid("t1_valid", n);
        check("t1_latency", n, 21);
        check("t1_q", out_q, 28);
        check("t1_r", out_r, 4);
        check("t1_dbz", out_dbz, 0);
        tick();
        check("t1_popped", out_valid, 0);
        check("t1_one_start", start_cnt - base, 1);

        // 55/0 handled locally
        base = start_cnt;
        push(8'd55, 8'd0);
        tick();
        check("t2_valid", out_valid, 1);
        check("t2_q", out_q, 255);
        check("t2_r", out_r, 55);
        check("t2_dbz", out_dbz, 1);
        tick();
        check("t2_no_start", start_cnt - base, 0);

        // Back-to-back pushes with downstream stalled
        out_ready  = 1'b0;
        core_delay = 3;
        exp_q[0] = 8'd3; exp_r[0] = 8'd1;
        exp_q[1] = 8'd4; exp_r[1] = 8'd1;
        exp_q[2] = 8'd8; exp_r[2] = 8'd0;
        push(8'd10, 8'd3);
        push(8'd9, 8'd2);
        in_valid = 1'b1; in_dividend = 8'd8; in_divisor = 8'd1;
        check("t3_stall", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            wait_valid("t3_valid", n);
            check("t3_q", out_q, exp_q[i]);
            check("t3_r", out_r, exp_r[i]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (i == 0) begin
                check("t3_third_accepted", in_ready, 1);
                tick();
                in_valid = 1'b0;
            end
        end
        check("t3_drained", busy, 0);

        // HOLD stability under core_done noise
        core_delay = 4;
        push(8'd100, 8'd9);
        wait_valid("t4_valid", n);
        check("t4_q", out_q, 11);
        check("t4_r", out_r, 1);
        hq = out_q; hr = out_r;
        noise = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!out_valid || out_q !== hq || out_r !== hr || out_dbz !== 1'b0) seen = 1'b1;
        end
        check("t4_stable", seen, 0);
        noise     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_popped", out_valid, 0);
        check("t4_single_pop", busy, 0);
        tick();
        check("t4_still_idle", busy, 0);

        // Reset while WAIT with two entries queued
        out_ready  = 1'b1;
        core_delay = 30;
        push(8'd50, 8'd5);
        push(8'd60, 8'd6);
        check("t5_start", start, 1);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("t5_start_rst", start, 0);
        check("t5_valid_rst", out_valid, 0);
        check("t5_q_rst", out_q, 0);
        check("t5_r_rst", out_r, 0);
        check("t5_dbz_rst", out_dbz, 0);
        check("t5_err_rst", out_err, 0);
        check("t5_busy_rst", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        check("t5_late_done_ignored", seen, 0);

`ifdef DIV_TIMEOUT_EN
        // Watchdog fires after 16 WAIT cycles, then next entry runs normally
        core_mute  = 1'b1;
        out_ready  = 1'b0;
        core_delay = 2;
        push(8'd70, 8'd7);
        push(8'd80, 8'd8);
        wait_start("t6_start");
        tick();
        wait_valid("t6_valid", n);
        check("t6_timeout_cycles", n, 16);
        check("t6_err", out_err, 1);
        check("t6_q", out_q, 0);
        check("t6_r", out_r, 0);
        check("t6_dbz", out_dbz, 0);
        core_mute = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_start("t6_next_start");
        wait_valid("t6_next_valid", n);
        check("t6_next_q", out_q, 10);
        check("t6_next_r", out_r, 0);
        check("t6_next_err", out_err, 0);
        out_ready = 1'b1;
        tick();
`else
        // Without the watchdog WAIT only exits on core_done
        core_mute = 1'b1;
        out_ready = 1'b1;
        push(8'd70, 8'd7);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("t6_no_exit", seen, 0);
        check("t6_busy", busy, 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        core_mute = 1'b0;
        check("t6_recovered", busy, 0);
`endif
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
